// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-to-writeback pipeline register. It captures one MEM entry per
//   cycle, forms the writeback value (ALU result, extracted load value or
//   link address PC+8), resolves the destination register and drives the
//   register-file write port and the forwarding bus. It also counts retired
//   (accepted) entries.
//
//   Optional feature macro: SUBWORD_LOAD_EN
//     defined   : byte/half load extraction with sign or zero extension
//     undefined : load results pass the raw memory word unchanged
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid              upstream entry valid
//   in_RegWrite           entry writes a register
//   in_RegDst[1:0]        destination select: 00 rc, 01 rb, 10 r1, 11 r31
//   in_rb, in_rc[4:0]     instruction register fields
//   in_sel[1:0]           result source: 00/11 ALU, 01 load, 10 link
//   in_alu/in_mem/in_pc   ALU result, raw load word, instruction PC
//   in_ld_size[1:0]       00/11 word, 01 byte, 10 half
//   in_ld_signed          sign-extend sub-word load
//   in_addr_lo[1:0]       load address bits [1:0]
//   stall, flush          hold stage / insert bubble (flush wins)
//   RegWrite, RegDst, rb, rc, wdata   register-file write port
//   fwd_valid, fwd_reg, fwd_data      forwarding bus
//   retire_cnt            accepted-entry count (wraps)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    in_RegWrite,
    input  logic [1:0]              in_RegDst,
    input  logic [4:0]              in_rb,
    input  logic [4:0]              in_rc,
    input  logic [1:0]              in_sel,
    input  logic [31:0]             in_alu,
    input  logic [31:0]             in_mem,
    input  logic [31:0]             in_pc,
    input  logic [1:0]              in_ld_size,
    input  logic                    in_ld_signed,
    input  logic [1:0]              in_addr_lo,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    RegWrite,
    output logic [1:0]              RegDst,
    output logic [4:0]              rb,
    output logic [4:0]              rc,
    output logic [31:0]             wdata,
    output logic                    fwd_valid,
    output logic [4:0]              fwd_reg,
    output logic [31:0]             fwd_data,
    output logic [RETIRE_CNT_W-1:0] retire_cnt
);

    // Map the destination select onto an architectural register number.
    function automatic logic [4:0] resolve_dst(input logic [1:0] dst,
                                               input logic [4:0] rb_f,
                                               input logic [4:0] rc_f);
        logic [4:0] r;
        case (dst)
            2'b00:   r = rc_f;
            2'b01:   r = rb_f;
            2'b10:   r = 5'd1;
            2'b11:   r = 5'd31;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

`ifdef SUBWORD_LOAD_EN
    // Little-endian sub-word extraction; half loads ignore address bit 0.
    function automatic logic [31:0] extract_load(input logic [31:0] mem,
                                                 input logic [1:0]  size,
                                                 input logic        sgn,
                                                 input logic [1:0]  addr);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] r;
        byte_sh = mem >> {addr, 3'b000};
        half_sh = mem >> {addr[1], 4'b0000};
        case (size)
            2'b01:   r = {{24{sgn & byte_sh[7]}}, byte_sh[7:0]};
            2'b10:   r = {{16{sgn & half_sh[15]}}, half_sh[15:0]};
            default: r = mem;
        endcase
        return r;
    endfunction
`endif

    logic        rw_s;
    logic [31:0] load_s;
    logic [31:0] result_s;
    logic [4:0]  dst_s;
    logic [1:0]  nxt_regdst_s;
    logic [4:0]  nxt_rb_s;
    logic [4:0]  nxt_rc_s;
    logic [31:0] nxt_wdata_s;
    logic [4:0]  nxt_fwd_reg_s;
    logic        nxt_fwd_valid_s;

`ifdef SUBWORD_LOAD_EN
    assign load_s = extract_load(in_mem, in_ld_size, in_ld_signed, in_addr_lo);
`else
    // Sub-word controls have no effect in this build.
    logic unused_load_ctrl_s;
    assign unused_load_ctrl_s = ^{in_ld_size, in_ld_signed, in_addr_lo};
    assign load_s = in_mem;
`endif

    // Next-entry values; non-writing entries are forced to an all-zero r0 write.
    always_comb begin
        rw_s            = in_valid & in_RegWrite;
        result_s        = in_alu;
        nxt_regdst_s    = 2'b00;
        nxt_rb_s        = 5'd0;
        nxt_rc_s        = 5'd0;
        nxt_wdata_s     = 32'd0;
        nxt_fwd_reg_s   = 5'd0;
        nxt_fwd_valid_s = 1'b0;
        case (in_sel)
            2'b01:   result_s = load_s;
            2'b10:   result_s = in_pc + 32'd8;
            default: result_s = in_alu;
        endcase
        dst_s = resolve_dst(in_RegDst, in_rb, in_rc);
        if (rw_s) begin
            nxt_regdst_s    = in_RegDst;
            nxt_rb_s        = in_rb;
            nxt_rc_s        = in_rc;
            nxt_wdata_s     = result_s;
            nxt_fwd_reg_s   = dst_s;
            nxt_fwd_valid_s = (dst_s != 5'd0);
        end else begin
            nxt_regdst_s    = 2'b00;
            nxt_rb_s        = 5'd0;
            nxt_rc_s        = 5'd0;
            nxt_wdata_s     = 32'd0;
            nxt_fwd_reg_s   = 5'd0;
            nxt_fwd_valid_s = 1'b0;
        end
    end

    // Stage register: flush inserts a bubble, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite   <= 1'b0;
            RegDst     <= 2'b00;
            rb         <= 5'd0;
            rc         <= 5'd0;
            wdata      <= 32'd0;
            fwd_valid  <= 1'b0;
            fwd_reg    <= 5'd0;
            retire_cnt <= '0;
        end else if (flush) begin
            RegWrite   <= 1'b0;
            RegDst     <= 2'b00;
            rb         <= 5'd0;
            rc         <= 5'd0;
            wdata      <= 32'd0;
            fwd_valid  <= 1'b0;
            fwd_reg    <= 5'd0;
        end else if (!stall) begin
            RegWrite   <= rw_s;
            RegDst     <= nxt_regdst_s;
            rb         <= nxt_rb_s;
            rc         <= nxt_rc_s;
            wdata      <= nxt_wdata_s;
            fwd_valid  <= nxt_fwd_valid_s;
            fwd_reg    <= nxt_fwd_reg_s;
            if (in_valid) begin
                retire_cnt <= retire_cnt + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Forwarded data is the registered write data itself.
    assign fwd_data = wdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_RegWrite, in_ld_signed, stall, flush;
    logic [1:0]    in_RegDst, in_sel, in_ld_size, in_addr_lo;
    logic [4:0]    in_rb, in_rc;
    logic [31:0]   in_alu, in_mem, in_pc;
    logic          RegWrite, fwd_valid;
    logic [1:0]    RegDst;
    logic [4:0]    rb, rc, fwd_reg;
    logic [31:0]   wdata, fwd_data;
    logic [CW-1:0] retire_cnt;

    int tests = 0;
    int failed = 0;

    // Reference state: expected outputs after the most recent edge.
    logic        m_rw;
    logic [1:0]  m_dst;
    logic [4:0]  m_rb, m_rc, m_freg;
    logic [31:0] m_wd;
    logic        m_fv;
    int unsigned m_cnt;

    mem_wb_stage #(.RETIRE_CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_RegWrite(in_RegWrite),
        .in_RegDst(in_RegDst), .in_rb(in_rb), .in_rc(in_rc), .in_sel(in_sel),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc), .in_ld_size(in_ld_size),
        .in_ld_signed(in_ld_signed), .in_addr_lo(in_addr_lo), .stall(stall), .flush(flush),
        .RegWrite(RegWrite), .RegDst(RegDst), .rb(rb), .rc(rc), .wdata(wdata),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".RegWrite"},   64'(RegWrite),   64'(m_rw));
        check({tag, ".RegDst"},     64'(RegDst),     64'(m_dst));
        check({tag, ".rb"},         64'(rb),         64'(m_rb));
        check({tag, ".rc"},         64'(rc),         64'(m_rc));
        check({tag, ".wdata"},      64'(wdata),      64'(m_wd));
        check({tag, ".fwd_valid"},  64'(fwd_valid),  64'(m_fv));
        check({tag, ".fwd_reg"},    64'(fwd_reg),    64'(m_freg));
        check({tag, ".fwd_data"},   64'(fwd_data),   64'(m_wd));
        check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(m_cnt % (1 << CW)));
    endtask

    // Load value from the arithmetic definition of little-endian extraction.
    function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] addr);
        logic [31:0] v;
`ifdef SUBWORD_LOAD_EN
        if (size == 2'd1) begin
            v = (mem / (32'd1 << (8 * addr))) % 32'd256;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd2) begin
            v = (mem / (32'd1 << (16 * (addr / 2)))) % 32'd65536;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = mem;
        end
`else
        v = mem;
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_rw = 1'b0; m_dst = 2'd0; m_rb = 5'd0; m_rc = 5'd0;
        m_wd = 32'd0; m_fv = 1'b0; m_freg = 5'd0; m_cnt = 0;
    endtask

    task automatic model_bubble();
        m_rw = 1'b0; m_dst = 2'd0; m_rb = 5'd0; m_rc = 5'd0;
        m_wd = 32'd0; m_fv = 1'b0; m_freg = 5'd0;
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_edge();
        logic [4:0] regs[4];
        if (flush) begin
            model_bubble();
        end else if (!stall) begin
            if (in_valid) m_cnt++;
            if (in_valid && in_RegWrite) begin
                regs[0] = in_rc; regs[1] = in_rb; regs[2] = 5'd1; regs[3] = 5'd31;
                m_rw = 1'b1; m_dst = in_RegDst; m_rb = in_rb; m_rc = in_rc;
                m_freg = regs[in_RegDst];
                m_fv = (m_freg != 5'd0);
                if (in_sel == 2'd1)      m_wd = ref_load(in_mem, in_ld_size, in_ld_signed, in_addr_lo);
                else if (in_sel == 2'd2) m_wd = in_pc + 32'd8;
                else                     m_wd = in_alu;
            end else begin
                model_bubble();
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_RegWrite = 1'b0; in_RegDst = 2'd0; in_rb = 5'd0; in_rc = 5'd0;
        in_sel = 2'd0; in_alu = 32'd0; in_mem = 32'd0; in_pc = 32'd0; in_ld_size = 2'd0;
        in_ld_signed = 1'b0; in_addr_lo = 2'd0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic rand_entry();
        in_valid = ($urandom_range(0, 7) != 0); in_RegWrite = ($urandom_range(0, 5) != 0);
        in_RegDst = 2'($urandom); in_rb = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
        in_rc = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
        in_sel = 2'($urandom); in_alu = $urandom; in_mem = $urandom; in_pc = $urandom;
        in_ld_size = 2'($urandom); in_ld_signed = 1'($urandom); in_addr_lo = 2'($urandom);
    endtask

    initial begin
        logic [CW-1:0] held_cnt;
        logic [31:0]   held_wd;
        idle_inputs();
        model_reset();
        reset_n = 1'b0;
        #12;
        check_all("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ALU write to r5
        in_valid = 1'b1; in_RegWrite = 1'b1; in_RegDst = 2'd0; in_rc = 5'd5; in_sel = 2'd0;
        in_alu = 32'h1234;
        tick("alu");
        check("alu.wdata_lit", 64'(wdata), 64'h1234);
        check("alu.cnt_lit", 64'(retire_cnt), 64'd1);

        // Load path
        in_sel = 2'd1; in_mem = 32'h80FF7F01; in_addr_lo = 2'd3; in_ld_size = 2'd1; in_ld_signed = 1'b1;
        tick("ldb_s");
`ifdef SUBWORD_LOAD_EN
        check("ldb_s.lit", 64'(wdata), 64'hFFFFFF80);
        in_ld_signed = 1'b0;
        tick("ldb_u");
        check("ldb_u.lit", 64'(wdata), 64'h00000080);
        in_ld_size = 2'd2; in_addr_lo = 2'd2; in_ld_signed = 1'b1;
        tick("ldh_s");
        check("ldh_s.lit", 64'(wdata), 64'hFFFF80FF);
`else
        check("ld_off.lit", 64'(wdata), 64'h80FF7F01);
`endif

        // Link to r31, then a write to r0 via rb
        in_RegDst = 2'd3; in_sel = 2'd2; in_pc = 32'h00400010;
        tick("link");
        check("link.reg_lit", 64'(fwd_reg), 64'd31);
        check("link.wd_lit", 64'(wdata), 64'h00400018);
        in_RegDst = 2'd1; in_rb = 5'd0; in_sel = 2'd0;
        tick("r0");
        check("r0.fv_lit", 64'(fwd_valid), 64'd0);

        // Capture, then stall three cycles with changing inputs
        in_RegDst = 2'd0; in_rc = 5'd9; in_alu = 32'hCAFE0001;
        tick("pre_stall");
        held_cnt = retire_cnt; held_wd = wdata;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_entry();
            tick("stall");
        end
        check("stall.cnt_held", 64'(retire_cnt), 64'(held_cnt));
        check("stall.wd_held", 64'(wdata), 64'(held_wd));
        flush = 1'b1; in_valid = 1'b1; in_RegWrite = 1'b1;
        tick("flush");
        check("flush.rw_lit", 64'(RegWrite), 64'd0);
        check("flush.cnt_held", 64'(retire_cnt), 64'(held_cnt));

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_entry();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            tick("rand");
        end

        // Asynchronous reset between edges, held across stall+flush
        idle_inputs();
        in_valid = 1'b1; in_RegWrite = 1'b1; in_rc = 5'd7; in_alu = 32'h55AA55AA;
        tick("pre_rst");
        #2;
        reset_n = 1'b0; stall = 1'b1; flush = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_held");
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0;
        tick("post_rst");
        check("post_rst.cnt_lit", 64'(retire_cnt), 64'd1);

        // Counter wrap: 16 accepted entries from reset
        reset_n = 1'b0; #1; model_reset(); reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_alu = $urandom;
            tick("wrap");
        end
        check("wrap.cnt_lit", 64'(retire_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: RETIRE_CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream MEM entry valid.
REQ-005 in_RegWrite  input  1  entry writes a register.
REQ-006 in_RegDst  input  2  destination select: 00 rc, 01 rb, 10 r1, 11 r31.
REQ-007 in_rb, in_rc  input  5 each  instruction register fields.
REQ-008 in_sel  input  2  result source: 00 ALU, 01 load, 10 link, 11 ALU.
REQ-009 in_alu, in_mem, in_pc  input  32 each  ALU result, raw load word, instruction PC.
REQ-010 in_ld_size  input  2  00 word, 01 byte, 10 half, 11 word.
REQ-011 in_ld_signed  input  1  sign-extend sub-word load.
REQ-012 in_addr_lo  input  2  load address bits [1:0].
REQ-013 stall  input  1  hold stage contents.
REQ-014 flush  input  1  kill entry being captured.
REQ-015 RegWrite, RegDst[1:0], rb[4:0], rc[4:0], wdata[31:0]  outputs  register-file write port.
REQ-016 fwd_valid  output  1; fwd_reg  output  5; fwd_data  output  32  forwarding bus.
REQ-017 retire_cnt  output  RETIRE_CNT_W  accepted-entry count.

Function
REQ-018 Single register stage, latency 1 cycle; all outputs registered, no input-to-output combinational path.
REQ-019 Edge with flush=1: stage loads bubble (valid=0) regardless of stall; flush has priority.
REQ-020 Edge with flush=0, stall=1: all outputs and retire_cnt hold.
REQ-021 Edge with flush=0, stall=0: capture in_* entry; bubble if in_valid=0.
REQ-022 Captured wdata: sel 00/11 in_alu; sel 01 extracted load value; sel 10 in_pc+32'd8, modulo 2^32.
REQ-023 Load extraction little-endian: byte = in_mem[8*in_addr_lo +: 8]; half = in_mem[16*in_addr_lo[1] +: 16], in_addr_lo[0] ignored; word = in_mem unchanged.
REQ-024 Sub-word extended to 32 bits: sign-extended if in_ld_signed=1, else zero-extended.
REQ-025 RegWrite output = valid & in_RegWrite; RegDst, rb, rc pass captured values when RegWrite=1.
REQ-026 When stage holds bubble or RegWrite=0: RegWrite=0, RegDst=00, rc=0, rb=0, wdata=0, so any default write targets r0.
REQ-027 fwd_reg = resolved destination (rc, rb, 5'd1, 5'd31 per RegDst); fwd_data = wdata.
REQ-028 fwd_valid = RegWrite & (fwd_reg != 0); writes resolving to r0 never forward.
REQ-029 retire_cnt increments by 1 on each edge capturing in_valid=1 with stall=0, flush=0; wraps all-ones to 0.

Reset
REQ-030 reset_n low asynchronously clears: valid=0, RegWrite=0, RegDst=00, rb=0, rc=0, wdata=0, fwd_valid=0, fwd_reg=0, fwd_data=0, retire_cnt=0.
REQ-031 Reset asserted mid-stall or mid-flush overrides both; first capture on first rising edge after reset_n high.

Configuration
REQ-032 Macro SUBWORD_LOAD_EN defined: REQ-023/REQ-024 extraction implemented.
REQ-033 SUBWORD_LOAD_EN undefined: in_ld_size, in_ld_signed, in_addr_lo ignored; sel 01 yields in_mem unchanged; all other behaviour identical.

Verification
REQ-034 ALU write: in_valid=1, RegWrite=1, RegDst=00, rc=5, sel=00, alu=0x1234 -> next cycle RegWrite=1, rc=5, wdata=0x1234, fwd_valid=1, fwd_reg=5, retire_cnt=1.
REQ-035 Signed byte load (macro on): mem=0x80FF7F01, addr_lo=3, size=01, signed=1 -> wdata=0xFFFFFF80; signed=0 -> 0x00000080; half addr_lo=2 signed -> 0xFFFF80FF.
REQ-036 Link: RegDst=11, sel=10, pc=0x00400010 -> fwd_reg=31, wdata=0x00400018; RegDst=01, rb=0 -> RegWrite=1, fwd_valid=0.
REQ-037 Stall/flush: capture entry, stall=1 for 3 cycles with changing inputs -> outputs and retire_cnt constant; stall=1 with flush=1 -> next cycle RegWrite=0, rc=0, retire_cnt unchanged.
REQ-038 Counter wrap and reset: RETIRE_CNT_W=4, 16 accepted entries -> retire_cnt=0; assert reset_n low between edges -> all outputs 0 immediately.
REQ-039 Macro off: sel=01, size=01, mem=0x80FF7F01 -> wdata=0x80FF7F01.
